trace_packet_streamer: RTL and testbench



---
 rtl/continuous_monitoring_system_pkg.sv | 27 ++
 rtl/event_counter_bank.sv | 48 ++++
 rtl/trace_packet_streamer.sv | 100 ++++++++++
 tb/tb_trace_packet_streamer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/continuous_monitoring_system_pkg.sv
`default_nettype none
// ============================================================================
// Module  : continuous_monitoring_system_pkg
// Brief   : Shared event-counter defaults and trace packet field offsets.
// Revision: 1.0
// ============================================================================
package continuous_monitoring_system_pkg;

    localparam int c_num_events    = 39;
    localparam int c_counter_width = 7;
    localparam int c_user_width    = 160;

    // Packet layout from LSB: counters, overflow map, user payload.
    function automatic int cnt_lsb();
        return 0;
    endfunction

    function automatic int ovf_lsb(input int num_events, input int counter_width);
        return num_events * counter_width;
    endfunction

    function automatic int user_lsb(input int num_events, input int counter_width);
        return num_events * (counter_width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_counter_bank.sv
`default_nettype none
// ============================================================================
// Module  : event_counter_bank
// Brief   : Per-event wrapping counters with sticky overflow flags and clear.
// Revision: 1.0
// ============================================================================
module event_counter_bank
    import continuous_monitoring_system_pkg::*;
#(
    parameter int NUM_EVENTS    = c_num_events,
    parameter int COUNTER_WIDTH = c_counter_width
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_EVENTS-1:0]               i_events,
    input  logic                                i_clear,
    output logic [NUM_EVENTS*COUNTER_WIDTH-1:0] o_counters,
    output logic [NUM_EVENTS-1:0]               o_overflow_map
);

    generate
        for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_ctr
            logic [COUNTER_WIDTH-1:0] r_cnt;
            logic                     r_ovf;

            // On clear the event of the clearing cycle seeds the counter so it is not lost.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (i_clear) begin
                    r_cnt <= COUNTER_WIDTH'(i_events[gi]);
                    r_ovf <= 1'b0;
                end else if (i_events[gi]) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_ovf <= 1'b1;
                    end
                end
            end

            assign o_counters[gi*COUNTER_WIDTH +: COUNTER_WIDTH] = r_cnt;
            assign o_overflow_map[gi]                            = r_ovf;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/trace_packet_streamer.sv
`default_nettype none
// ============================================================================
// Module  : trace_packet_streamer
// Brief   : Snapshots event counters into AXI-Stream trace packets with framing.
// Revision: 1.0
// ============================================================================
module trace_packet_streamer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int NUM_EVENTS              = c_num_events,
    parameter int COUNTER_WIDTH           = c_counter_width,
    parameter int USER_WIDTH              = c_user_width,
    parameter bit WRITE_POSEDGE_TRIGGERED = 1'b0,
    localparam int DATA_WIDTH             = USER_WIDTH + NUM_EVENTS*(COUNTER_WIDTH+1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_EVENTS-1:0]               events,
    input  logic                                wr_en,
    input  logic [USER_WIDTH-1:0]               user_data,
    input  logic                                last_in,
    input  logic [31:0]                         tlast_interval,
    output logic                                M_AXIS_tvalid,
    input  logic                                M_AXIS_tready,
    output logic [DATA_WIDTH-1:0]               M_AXIS_tdata,
    output logic                                M_AXIS_tlast,
    output logic [NUM_EVENTS*COUNTER_WIDTH-1:0] counters,
    output logic [NUM_EVENTS-1:0]               overflow_map,
    output logic                                drop
);

    localparam int c_cnt_lsb  = cnt_lsb();
    localparam int c_ovf_lsb  = ovf_lsb(NUM_EVENTS, COUNTER_WIDTH);
    localparam int c_user_lsb = user_lsb(NUM_EVENTS, COUNTER_WIDTH);

    logic                  r_wr_en_q;
    logic                  r_tvalid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tlast;
    logic                  r_drop;
    logic [31:0]           r_frame_cnt;

    logic                  w_wstb;
    logic                  w_accept;
    logic                  w_interval_hit;
    logic                  w_tlast;
    logic [DATA_WIDTH-1:0] w_packet;

    assign w_wstb   = wr_en & ~(WRITE_POSEDGE_TRIGGERED & r_wr_en_q);
    assign w_accept = w_wstb & (~r_tvalid | M_AXIS_tready);

    event_counter_bank #(
        .NUM_EVENTS    (NUM_EVENTS),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_bank (
        .clk            (clk),
        .rst            (rst),
        .i_events       (events),
        .i_clear        (w_wstb),
        .o_counters     (counters),
        .o_overflow_map (overflow_map)
    );

    assign w_packet[c_cnt_lsb  +: NUM_EVENTS*COUNTER_WIDTH] = counters;
    assign w_packet[c_ovf_lsb  +: NUM_EVENTS]               = overflow_map;
    assign w_packet[c_user_lsb +: USER_WIDTH]               = user_data;

    // Using >= lets a shrunken interval close the frame on the very next packet.
    assign w_interval_hit = (tlast_interval != 32'd0) && (r_frame_cnt >= (tlast_interval - 32'd1));
    assign w_tlast        = last_in | w_interval_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en_q   <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_drop      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_wr_en_q <= wr_en;
            r_drop    <= w_wstb & r_tvalid & ~M_AXIS_tready;
            if (w_accept) begin
                r_tvalid    <= 1'b1;
                r_tdata     <= w_packet;
                r_tlast     <= w_tlast;
                r_frame_cnt <= w_tlast ? 32'd0 : r_frame_cnt + 32'd1;
            end else if (r_tvalid && M_AXIS_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign M_AXIS_tvalid = r_tvalid;
    assign M_AXIS_tdata  = r_tdata;
    assign M_AXIS_tlast  = r_tlast;
    assign drop          = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_trace_packet_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tb_trace_packet_streamer
// Brief   : Scoreboard bench for trace_packet_streamer (level and edge write).
// Revision: 1.0
// ============================================================================
module tb_trace_packet_streamer;

    localparam int NE = 39;
    localparam int CW = 7;
    localparam int UW = 160;
    localparam int DW = UW + NE*(CW+1);

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [NE-1:0]    events,    events_b;
    logic             wr_en,     wr_en_b;
    logic [UW-1:0]    user_data, user_b;
    logic             last_in,   last_b;
    logic [31:0]      interval,  interval_b;
    logic             tready,    tready_b;
    logic             tvalid,    tvalid_b;
    logic [DW-1:0]    tdata,     tdata_b;
    logic             tlast,     tlast_b;
    logic [NE*CW-1:0] counters,  counters_b;
    logic [NE-1:0]    ovf,       ovf_b;
    logic             drop,      drop_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;
    int   hs_b   = 0;
    logic [NE*CW-1:0] cv;
    logic [NE-1:0]    ov;

    always #5 clk = ~clk;

    trace_packet_streamer dut_a (
        .clk(clk), .rst(rst), .events(events), .wr_en(wr_en), .user_data(user_data),
        .last_in(last_in), .tlast_interval(interval), .M_AXIS_tvalid(tvalid),
        .M_AXIS_tready(tready), .M_AXIS_tdata(tdata), .M_AXIS_tlast(tlast),
        .counters(counters), .overflow_map(ovf), .drop(drop)
    );

    trace_packet_streamer #(.WRITE_POSEDGE_TRIGGERED(1'b1)) dut_b (
        .clk(clk), .rst(rst), .events(events_b), .wr_en(wr_en_b), .user_data(user_b),
        .last_in(last_b), .tlast_interval(interval_b), .M_AXIS_tvalid(tvalid_b),
        .M_AXIS_tready(tready_b), .M_AXIS_tdata(tdata_b), .M_AXIS_tlast(tlast_b),
        .counters(counters_b), .overflow_map(ovf_b), .drop(drop_b)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] pkt(input logic [UW-1:0] u, input logic [NE-1:0] o,
                                          input logic [NE*CW-1:0] c);
        return {u, o, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic write_a(input logic [UW-1:0] u, input logic l, input logic [NE*CW-1:0] c,
                           input logic [NE-1:0] o, input logic exp_l);
        wr_en     = 1'b1;
        user_data = u;
        last_in   = l;
        qa.push_back('{d: pkt(u, o, c), l: exp_l});
        tick();
        wr_en   = 1'b0;
        last_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && tvalid && tready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pkt_a_unexpected actual=%0h required=none", tdata);
            end else begin
                ea = qa.pop_front();
                chk("pkt_a_data", tdata, ea.d);
                chk("pkt_a_last", DW'(tlast), DW'(ea.l));
            end
        end
        if (!rst && tvalid_b && tready_b) begin
            hs_b++;
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pkt_b_unexpected actual=%0h required=none", tdata_b);
            end else begin
                eb = qb.pop_front();
                chk("pkt_b_data", tdata_b, eb.d);
                chk("pkt_b_last", DW'(tlast_b), DW'(eb.l));
            end
        end
    end

    initial begin
        rst = 1'b1;
        events = '0; wr_en = 1'b0; user_data = '0; last_in = 1'b0; interval = '0; tready = 1'b1;
        events_b = '0; wr_en_b = 1'b0; user_b = '0; last_b = 1'b0; interval_b = '0; tready_b = 1'b1;
        repeat (2) tick();
        chk("rst_tvalid", DW'(tvalid), '0);
        chk("rst_tdata", tdata, '0);
        chk("rst_tlast", DW'(tlast), '0);
        chk("rst_drop", DW'(drop), '0);
        chk("rst_counters", DW'(counters), '0);
        chk("rst_ovf", DW'(ovf), '0);
        rst = 1'b0;

        // events[1] for 5 cycles, then write with events idle
        events[1] = 1'b1;
        repeat (5) tick();
        chk("cnt1_live5", DW'(counters[13:7]), DW'(5));
        events = '0;
        cv = '0; cv[13:7] = 7'd5;
        write_a(160'h1111, 1'b0, cv, '0, 1'b0);
        chk("cnt_clear_after_wr", DW'(counters), '0);
        // event present in the write cycle seeds the fresh counter
        events[1] = 1'b1;
        repeat (2) tick();
        cv = '0; cv[13:7] = 7'd2;
        events[1] = 1'b1;
        write_a(160'h2222, 1'b0, cv, '0, 1'b0);
        events = '0;
        chk("cnt1_seed_after_wr", DW'(counters[13:7]), DW'(1));
        tick();

        // events[0] for 130 cycles: wraps once to 2 with overflow
        do_reset();
        events[0] = 1'b1;
        repeat (130) tick();
        events = '0;
        chk("cnt0_wrap", DW'(counters[6:0]), DW'(2));
        chk("ovf0_set", DW'(ovf), DW'(1));
        cv = '0; cv[6:0] = 7'd2;
        ov = '0; ov[0] = 1'b1;
        write_a(160'h3333, 1'b0, cv, ov, 1'b0);
        chk("ovf_clear_after_wr", DW'(ovf), '0);
        tick();

        // interval 3: tlast on packets 3 and 6
        do_reset();
        interval = 32'd3;
        for (int i = 0; i < 7; i++) begin
            write_a(160'(32'h100 + i), 1'b0, '0, '0, (i == 2) || (i == 5));
        end
        tick();
        interval = 32'd0;

        // backpressure: first packet held, second dropped, counters still cleared
        do_reset();
        tready = 1'b0;
        write_a(160'hAAAA, 1'b0, '0, '0, 1'b0);
        chk("hold_tvalid", DW'(tvalid), DW'(1));
        events[2] = 1'b1;
        repeat (3) tick();
        events = '0;
        wr_en = 1'b1; user_data = 160'hBBBB;
        tick();
        wr_en = 1'b0;
        chk("drop_pulse", DW'(drop), DW'(1));
        chk("drop_tvalid_stays", DW'(tvalid), DW'(1));
        chk("drop_tdata_held", tdata, pkt(160'hAAAA, '0, '0));
        chk("drop_counters_cleared", DW'(counters), '0);
        tick();
        chk("drop_one_pulse", DW'(drop), '0);
        chk("hold_tdata_stable", tdata, pkt(160'hAAAA, '0, '0));
        tready = 1'b1;
        tick();
        tick();
        chk("tvalid_drops", DW'(tvalid), '0);

        // last_in on write 2 only, then reset while holding
        do_reset();
        write_a(160'h51, 1'b0, '0, '0, 1'b0);
        write_a(160'h52, 1'b1, '0, '0, 1'b1);
        write_a(160'h53, 1'b0, '0, '0, 1'b0);
        tick();
        tready = 1'b0;
        wr_en = 1'b1; user_data = 160'h54;
        tick();
        wr_en = 1'b0;
        chk("mid_hold_tvalid", DW'(tvalid), DW'(1));
        rst = 1'b1; wr_en = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        chk("rst_mid_hold_tvalid", DW'(tvalid), '0);
        chk("rst_mid_hold_tdata", tdata, '0);
        tready = 1'b1;
        tick();

        // rising-edge write: level held 4 cycles gives exactly one packet
        do_reset();
        hs_b = 0;
        wr_en_b = 1'b1; user_b = 160'hE0E0;
        qb.push_back('{d: pkt(160'hE0E0, '0, '0), l: 1'b0});
        repeat (4) tick();
        wr_en_b = 1'b0;
        repeat (4) tick();
        chk("edge_one_packet", DW'(hs_b), DW'(1));

        chk("qa_drained", DW'(qa.size()), '0);
        chk("qb_drained", DW'(qb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
